// File: rtl/control_sequencer_pkg.sv
// Shared constants and types for the hard-wired control sequencer:
// opcodes, IR field positions, FSM states, opcode classes and the control bundle.
package control_sequencer_pkg;

  localparam int DATA_W    = 32;
  localparam int OPCODE_W  = 5;
  localparam int REG_IDX_W = 4;

  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RESET, ST_IDLE, ST_T0, ST_T1, ST_T1W, ST_T2,
    ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU3, CL_ALU2, CL_MULDIV, CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic pc_select, z_hi_select, z_lo_select, mdr_select;
    logic pc_enable, pc_increment_enable, ir_enable, y_enable, z_enable;
    logic mar_enable, mdr_enable, hi_enable, lo_enable, read;
    logic [OPCODE_W-1:0]  alu_instruction;
    logic                 reg_out_select;
    logic [REG_IDX_W-1:0] reg_out_index;
    logic                 reg_in_enable;
    logic [REG_IDX_W-1:0] reg_in_index;
    logic instr_done, illegal_op, halted;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
// Handshake: memory read data is valid on the cycle mem_ready is high while read is asserted; no backpressure elsewhere.
interface control_sequencer_if #(parameter int COUNT_W = 16);
  import control_sequencer_pkg::*;

  logic                 run;
  logic                 mem_ready;
  logic [DATA_W-1:0]    IR_Data;
  logic PC_select, Z_HI_select, Z_LO_select, MDR_select;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable;
  logic HI_enable, LO_enable, read;
  logic [OPCODE_W-1:0]  alu_instruction;
  logic                 reg_out_select;
  logic [REG_IDX_W-1:0] reg_out_index;
  logic                 reg_in_enable;
  logic [REG_IDX_W-1:0] reg_in_index;
  logic                 instr_done, illegal_op, halted;
  logic [COUNT_W-1:0]   instr_count;
  state_t               state_dbg;

  modport master (
    input  run, mem_ready, IR_Data,
    output PC_select, Z_HI_select, Z_LO_select, MDR_select,
           PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable,
           HI_enable, LO_enable, read, alu_instruction,
           reg_out_select, reg_out_index, reg_in_enable, reg_in_index,
           instr_done, illegal_op, halted, instr_count, state_dbg
  );

  modport slave (
    output run, mem_ready, IR_Data,
    input  PC_select, Z_HI_select, Z_LO_select, MDR_select,
           PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable,
           HI_enable, LO_enable, read, alu_instruction,
           reg_out_select, reg_out_index, reg_in_enable, reg_in_index,
           instr_done, illegal_op, halted, instr_count, state_dbg
  );
endinterface

// File: rtl/control_sequencer_decoder.sv
// Combinational opcode classifier: maps IR[31:27] onto the execute-sequence class.
module control_sequencer_decoder
  import control_sequencer_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class
);

  always_comb begin
    op_class = CL_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class = CL_ALU3;
      OP_NEG, OP_NOT:                 op_class = CL_ALU2;
      OP_MUL, OP_DIV:                 op_class = CL_MULDIV;
      OP_NOP:                         op_class = CL_NOP;
      OP_HALT:                        op_class = CL_HALT;
      default:                        op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired control unit: fetch T0-T2, then opcode-class execute steps T3-T6.
// Outputs are decoded from the state and the datapath's registered IR.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input logic clk,
  input logic reset,
  control_sequencer_if.master bus
);

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  op_class_t            op_class;
  ctrl_t                c;
  logic                 done;
  logic [OPCODE_W-1:0]  opcode;
  logic [REG_IDX_W-1:0] ra, rb, rc;

  assign opcode = bus.IR_Data[OP_LSB +: OPCODE_W];
  assign ra     = bus.IR_Data[RA_LSB +: REG_IDX_W];
  assign rb     = bus.IR_Data[RB_LSB +: REG_IDX_W];
  assign rc     = bus.IR_Data[RC_LSB +: REG_IDX_W];

  control_sequencer_decoder u_decoder (.opcode(opcode), .op_class(op_class));

  always_comb begin
    c       = '0;
    done    = 1'b0;
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE:  if (bus.run) state_d = ST_T0;
      ST_T0: begin
        c.pc_select = 1'b1; c.mar_enable = 1'b1; c.pc_increment_enable = 1'b1; c.z_enable = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        c.z_lo_select = 1'b1; c.pc_enable = 1'b1; c.read = 1'b1;
        state_d = ST_T1W;
      end
      ST_T1W: begin
        c.read       = 1'b1;
        c.mdr_enable = bus.mem_ready;
        if (bus.mem_ready) state_d = ST_T2;
      end
      ST_T2: begin
        c.mdr_select = 1'b1; c.ir_enable = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        case (op_class)
          CL_ALU3, CL_MULDIV: begin
            c.reg_out_select = 1'b1;
            c.reg_out_index  = (op_class == CL_MULDIV) ? ra : rb;
            c.y_enable       = 1'b1;
            state_d          = ST_T4;
          end
          CL_ALU2: begin
            c.reg_out_select = 1'b1; c.reg_out_index = rb;
            c.alu_instruction = opcode; c.z_enable = 1'b1;
            state_d = ST_T4;
          end
          CL_ILLEGAL: begin
            c.illegal_op = 1'b1;
            done = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      ST_T4: begin
        case (op_class)
          CL_ALU2: begin
            c.z_lo_select = 1'b1; c.reg_in_enable = 1'b1; c.reg_in_index = ra;
            done = 1'b1;
          end
          CL_ALU3, CL_MULDIV: begin
            c.reg_out_select  = 1'b1;
            c.reg_out_index   = (op_class == CL_MULDIV) ? rb : rc;
            c.alu_instruction = opcode; c.z_enable = 1'b1;
            state_d = ST_T5;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_T5: begin
        c.z_lo_select = 1'b1;
        if (op_class == CL_MULDIV) begin
          c.lo_enable = 1'b1;
          state_d = ST_T6;
        end else begin
          c.reg_in_enable = 1'b1; c.reg_in_index = ra;
          done = 1'b1;
        end
      end
      ST_T6: begin
        c.z_hi_select = 1'b1; c.hi_enable = 1'b1;
        done = 1'b1;
      end
      ST_HALT: c.halted = 1'b1;
      default: state_d = ST_RESET;
    endcase
    c.instr_done = done;
    // run is only consulted at the instruction boundary, so a mid-instruction drop still retires.
    if (done) begin
      count_d = count_q + 1'b1;
      if (op_class == CL_HALT) state_d = ST_HALT;
      else                     state_d = bus.run ? ST_T0 : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign bus.PC_select           = c.pc_select;
  assign bus.Z_HI_select         = c.z_hi_select;
  assign bus.Z_LO_select         = c.z_lo_select;
  assign bus.MDR_select          = c.mdr_select;
  assign bus.PC_enable           = c.pc_enable;
  assign bus.PC_increment_enable = c.pc_increment_enable;
  assign bus.IR_enable           = c.ir_enable;
  assign bus.Y_enable            = c.y_enable;
  assign bus.Z_enable            = c.z_enable;
  assign bus.MAR_enable          = c.mar_enable;
  assign bus.MDR_enable          = c.mdr_enable;
  assign bus.HI_enable           = c.hi_enable;
  assign bus.LO_enable           = c.lo_enable;
  assign bus.read                = c.read;
  assign bus.alu_instruction     = c.alu_instruction;
  assign bus.reg_out_select      = c.reg_out_select;
  assign bus.reg_out_index       = c.reg_out_index;
  assign bus.reg_in_enable       = c.reg_in_enable;
  assign bus.reg_in_index        = c.reg_in_index;
  assign bus.instr_done          = c.instr_done;
  assign bus.illegal_op          = c.illegal_op;
  assign bus.halted              = c.halted;
  assign bus.instr_count         = count_q;
  assign bus.state_dbg           = state_q;

endmodule
